// File: rtl/wb_merge_queue_2w_pkg.sv
// Shared constants, helpers and entry type for the writeback merge queue and RAM wrappers.
package wb_merge_queue_2w_pkg;

  localparam int unsigned WbAddrWidth = 5;
  localparam int unsigned WbDataWidth = 32;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  typedef struct packed {
    logic [WbAddrWidth-1:0] addr;
    logic [WbDataWidth-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_merge_queue_fwd_match.sv
// Youngest-match lookup over the queued entries, scanned from head (oldest) to tail-1 (youngest).
module wb_merge_queue_fwd_match
  import wb_merge_queue_2w_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WbAddrWidth,
  parameter int unsigned DATA_WIDTH = WbDataWidth,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_WIDTH  = log2_ceil(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data,
  input  logic [PTR_WIDTH-1:0]             head,
  input  logic [PTR_WIDTH:0]               count,
  input  logic [ADDR_WIDTH-1:0]            q_addr,
  output logic                             q_hit,
  output logic [DATA_WIDTH-1:0]            q_data
);

  logic [PTR_WIDTH-1:0] idx;

  // Later (younger) matches overwrite earlier ones, giving youngest-wins priority.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_WIDTH'(i);
      if (((PTR_WIDTH + 1)'(i) < count) && (entry_addr[idx] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_merge_queue_2w.sv
// Two-in/two-out in-order writeback queue feeding a 2W1R register-file RAM.
// Optional forwarding lookup port enabled by WB_MERGE_QUEUE_FWD_EN.
module wb_merge_queue_2w
  import wb_merge_queue_2w_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WbAddrWidth,
  parameter int unsigned DATA_WIDTH = WbDataWidth,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid0,
  input  logic [ADDR_WIDTH-1:0] in_addr0,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic                  in_valid1,
  input  logic [ADDR_WIDTH-1:0] in_addr1,
  input  logic [DATA_WIDTH-1:0] in_data1,
  output logic                  in_ready,
  input  logic                  drain_hold,
  output logic                  we1,
  output logic [ADDR_WIDTH-1:0] waddr1,
  output logic [DATA_WIDTH-1:0] wdata1,
  output logic                  we2,
  output logic [ADDR_WIDTH-1:0] waddr2,
  output logic [DATA_WIDTH-1:0] wdata2,
  output logic                  pending
`ifdef WB_MERGE_QUEUE_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_WIDTH-1:0] q_data
`endif
);

  localparam int unsigned PtrW = log2_ceil(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - 2);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1, slot1_ptr;
  logic [CntW-1:0] count_q, count_d, n_enq, n_deq;
  logic            en0, en1;

  // Conservative: a same-cycle dequeue is not credited.
  assign in_ready = (count_q <= ReadyMax);
  assign pending  = (count_q != '0);

  assign head_p1 = head_q + PtrW'(1);
  assign tail_p1 = tail_q + PtrW'(1);

  assign en0       = in_ready & in_valid0;
  assign en1       = in_ready & in_valid1;
  assign slot1_ptr = en0 ? tail_p1 : tail_q;

  assign we1    = (count_q >= CntW'(1)) & ~drain_hold;
  assign we2    = (count_q >= CntW'(2)) & ~drain_hold;
  assign waddr1 = addr_q[head_q];
  assign wdata1 = data_q[head_q];
  assign waddr2 = addr_q[head_p1];
  assign wdata2 = data_q[head_p1];

  always_comb begin
    n_enq   = CntW'(en0) + CntW'(en1);
    n_deq   = CntW'(we1) + CntW'(we2);
    head_d  = head_q + PtrW'(n_deq);
    tail_d  = tail_q + PtrW'(n_enq);
    count_d = count_q + n_enq - n_deq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (en0) begin
      addr_q[tail_q] <= in_addr0;
      data_q[tail_q] <= in_data0;
    end
    if (en1) begin
      addr_q[slot1_ptr] <= in_addr1;
      data_q[slot1_ptr] <= in_data1;
    end
  end

`ifdef WB_MERGE_QUEUE_FWD_EN
  wb_merge_queue_fwd_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PtrW)
  ) u_fwd_match (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .head       (head_q),
    .count      (count_q),
    .q_addr     (q_addr),
    .q_hit      (q_hit),
    .q_data     (q_data)
  );
`endif

endmodule
